// File: rtl/pipe_pkg.sv
// Shared definitions for the ID/EX pipeline stage.
//   - ALU opcode encodings consumed by the downstream 32-bit ALU
//   - MIPS-style primary opcode and R-type funct constants
//   - Decoded control word type, the bubble control word and a decode helper
//   - Default datapath / register-address widths
package pipe_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int REG_AW_DEF = 5;

   // ALU opcodes
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_LUI = 3'b011;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   // Primary opcodes
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   // R-type funct codes
   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   typedef struct packed {
      logic [2:0] alu_op;
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic       branch;
      logic       alu_src;   // reg2 takes the extended immediate
      logic       sext;      // sign- (1) or zero- (0) extend imm16
      logic       dest_rd;   // destination is rd (R-type) rather than rt
      logic       illegal;
   } ctrl_t;

   // A bubble performs a harmless ADD that writes nothing.
   localparam ctrl_t CTRL_BUBBLE = '{ALU_ADD, 1'b0, 1'b0, 1'b0, 1'b0,
                                     1'b0, 1'b0, 1'b0, 1'b0};

   function automatic ctrl_t decode(input logic [5:0] opcode,
                                    input logic [5:0] funct);
      ctrl_t c;
      c = CTRL_BUBBLE;
      case (opcode)
         OP_RTYPE: begin
            c.reg_write = 1'b1;
            c.dest_rd   = 1'b1;
            case (funct)
               FN_ADD:  c.alu_op = ALU_ADD;
               FN_SUB:  c.alu_op = ALU_SUB;
               FN_AND:  c.alu_op = ALU_AND;
               FN_OR:   c.alu_op = ALU_OR;
               FN_SLT:  c.alu_op = ALU_SLT;
               default: begin
                  c         = CTRL_BUBBLE;
                  c.illegal = 1'b1;
               end
            endcase
         end
         OP_ADDI: begin c.alu_op = ALU_ADD; c.reg_write = 1'b1; c.alu_src = 1'b1; c.sext = 1'b1; end
         OP_SLTI: begin c.alu_op = ALU_SLT; c.reg_write = 1'b1; c.alu_src = 1'b1; c.sext = 1'b1; end
         OP_ANDI: begin c.alu_op = ALU_AND; c.reg_write = 1'b1; c.alu_src = 1'b1; end
         OP_ORI:  begin c.alu_op = ALU_OR;  c.reg_write = 1'b1; c.alu_src = 1'b1; end
         // lui: the raw imm16 goes to the ALU, which does the shift itself
         OP_LUI:  begin c.alu_op = ALU_LUI; c.reg_write = 1'b1; c.alu_src = 1'b1; end
         OP_LW: begin
            c.alu_op = ALU_ADD; c.reg_write = 1'b1; c.mem_read = 1'b1;
            c.alu_src = 1'b1; c.sext = 1'b1;
         end
         OP_SW: begin
            c.alu_op = ALU_ADD; c.mem_write = 1'b1; c.alu_src = 1'b1; c.sext = 1'b1;
         end
         OP_BEQ: begin c.alu_op = ALU_SUB; c.branch = 1'b1; c.sext = 1'b1; end
         default: c.illegal = 1'b1;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/id_ex_fwd_mux.sv
// Operand forwarding mux for one source register.
// Config macro: ID_EX_FORWARD_EN -- when defined, EX/MEM and MEM/WB results
// bypass the registered register-file data; when undefined the registered
// data is passed through and the mem_*/wb_* inputs are ignored.
// Ports:
//   src_addr/src_data      registered source register address and RF data
//   mem_reg_write/rd/result  EX/MEM producer
//   wb_reg_write/rd/result   MEM/WB producer
//   fwd_data               resolved operand
module id_ex_fwd_mux
   import pipe_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int REG_AW = REG_AW_DEF
) (
   input  logic [REG_AW-1:0] src_addr,
   input  logic [DATA_W-1:0] src_data,
   input  logic              mem_reg_write,
   input  logic [REG_AW-1:0] mem_rd,
   input  logic [DATA_W-1:0] mem_result,
   input  logic              wb_reg_write,
   input  logic [REG_AW-1:0] wb_rd,
   input  logic [DATA_W-1:0] wb_result,
   output logic [DATA_W-1:0] fwd_data
);

`ifdef ID_EX_FORWARD_EN
   always_comb begin
      fwd_data = src_data;
      // r0 is hard-wired zero, so a "write" to it must never be bypassed.
      // MEM is the younger producer and therefore wins over WB.
      if (src_addr != '0) begin
         if (mem_reg_write && (mem_rd == src_addr)) begin
            fwd_data = mem_result;
         end else if (wb_reg_write && (wb_rd == src_addr)) begin
            fwd_data = wb_result;
         end
      end
   end
`else
   assign fwd_data = src_data;

   logic unused_fwd;
   assign unused_fwd = ^{src_addr, mem_reg_write, mem_rd, mem_result,
                         wb_reg_write, wb_rd, wb_result};
`endif

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register and ALU operand-select stage.
// Config macro: ID_EX_FORWARD_EN enables EX/MEM and MEM/WB forwarding.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   id_*                  decoded fields and RF read data from ID
//   stall, flush          hold contents / insert bubble (flush wins)
//   mem_*, wb_*           downstream producers used for forwarding
//   ex_*                  registered controls and resolved ALU operands
module id_ex_stage
   import pipe_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int REG_AW = REG_AW_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic [5:0]        id_opcode,
   input  logic [5:0]        id_funct,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic [REG_AW-1:0] id_rd,
   input  logic [DATA_W-1:0] id_rs_data,
   input  logic [DATA_W-1:0] id_rt_data,
   input  logic [15:0]       id_imm,
   input  logic              stall,
   input  logic              flush,
   input  logic              mem_reg_write,
   input  logic [REG_AW-1:0] mem_rd,
   input  logic [DATA_W-1:0] mem_result,
   input  logic              wb_reg_write,
   input  logic [REG_AW-1:0] wb_rd,
   input  logic [DATA_W-1:0] wb_result,
   output logic              ex_valid,
   output logic [DATA_W-1:0] ex_reg1,
   output logic [DATA_W-1:0] ex_reg2,
   output logic [2:0]        ex_alu_op,
   output logic [REG_AW-1:0] ex_dest,
   output logic              ex_reg_write,
   output logic              ex_mem_read,
   output logic              ex_mem_write,
   output logic              ex_branch,
   output logic [DATA_W-1:0] ex_store_data,
   output logic              ex_illegal
);

   logic              valid_q,   valid_d;
   ctrl_t             ctrl_q,    ctrl_d;
   logic [REG_AW-1:0] dest_q,    dest_d;
   logic [REG_AW-1:0] rs_q,      rs_d;
   logic [REG_AW-1:0] rt_q,      rt_d;
   logic [DATA_W-1:0] rs_data_q, rs_data_d;
   logic [DATA_W-1:0] rt_data_q, rt_data_d;
   logic [DATA_W-1:0] imm_q,     imm_d;

   ctrl_t             dec_ctrl;
   logic [DATA_W-1:0] dec_imm;

   always_comb begin
      dec_ctrl = decode(id_opcode, id_funct);
      dec_imm  = dec_ctrl.sext ? {{(DATA_W-16){id_imm[15]}}, id_imm}
                               : {{(DATA_W-16){1'b0}}, id_imm};
   end

   always_comb begin
      valid_d   = valid_q;
      ctrl_d    = ctrl_q;
      dest_d    = dest_q;
      rs_d      = rs_q;
      rt_d      = rt_q;
      rs_data_d = rs_data_q;
      rt_data_d = rt_data_q;
      imm_d     = imm_q;
      // An empty ID slot is treated exactly like a flush, but only when the
      // stage is free to advance; a stalled stage keeps its instruction.
      if (flush || (!stall && !id_valid)) begin
         valid_d   = 1'b0;
         ctrl_d    = CTRL_BUBBLE;
         dest_d    = '0;
         rs_d      = '0;
         rt_d      = '0;
         rs_data_d = '0;
         rt_data_d = '0;
         imm_d     = '0;
      end else if (!stall) begin
         valid_d   = 1'b1;
         ctrl_d    = dec_ctrl;
         dest_d    = dec_ctrl.illegal ? '0 : (dec_ctrl.dest_rd ? id_rd : id_rt);
         rs_d      = id_rs;
         rt_d      = id_rt;
         rs_data_d = id_rs_data;
         rt_data_d = id_rt_data;
         imm_d     = dec_imm;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q   <= 1'b0;
         ctrl_q    <= CTRL_BUBBLE;
         dest_q    <= '0;
         rs_q      <= '0;
         rt_q      <= '0;
         rs_data_q <= '0;
         rt_data_q <= '0;
         imm_q     <= '0;
      end else begin
         valid_q   <= valid_d;
         ctrl_q    <= ctrl_d;
         dest_q    <= dest_d;
         rs_q      <= rs_d;
         rt_q      <= rt_d;
         rs_data_q <= rs_data_d;
         rt_data_q <= rt_data_d;
         imm_q     <= imm_d;
      end
   end

   logic [DATA_W-1:0] rs_fwd;
   logic [DATA_W-1:0] rt_fwd;

   id_ex_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs (
      .src_addr      (rs_q),
      .src_data      (rs_data_q),
      .mem_reg_write (mem_reg_write),
      .mem_rd        (mem_rd),
      .mem_result    (mem_result),
      .wb_reg_write  (wb_reg_write),
      .wb_rd         (wb_rd),
      .wb_result     (wb_result),
      .fwd_data      (rs_fwd)
   );

   id_ex_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rt (
      .src_addr      (rt_q),
      .src_data      (rt_data_q),
      .mem_reg_write (mem_reg_write),
      .mem_rd        (mem_rd),
      .mem_result    (mem_result),
      .wb_reg_write  (wb_reg_write),
      .wb_rd         (wb_rd),
      .wb_result     (wb_result),
      .fwd_data      (rt_fwd)
   );

   assign ex_valid      = valid_q;
   assign ex_alu_op     = ctrl_q.alu_op;
   assign ex_dest       = dest_q;
   assign ex_reg_write  = ctrl_q.reg_write;
   assign ex_mem_read   = ctrl_q.mem_read;
   assign ex_mem_write  = ctrl_q.mem_write;
   assign ex_branch     = ctrl_q.branch;
   assign ex_illegal    = ctrl_q.illegal;
   assign ex_reg1       = rs_fwd;
   assign ex_reg2       = ctrl_q.alu_src ? imm_q : rt_fwd;
   assign ex_store_data = rt_fwd;

   // Extension and destination choice are already folded into imm_q/dest_q.
   logic unused_ctrl;
   assign unused_ctrl = ^{ctrl_q.sext, ctrl_q.dest_rd};

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;
   import pipe_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        id_valid;
   logic [5:0]  id_opcode;
   logic [5:0]  id_funct;
   logic [4:0]  id_rs, id_rt, id_rd;
   logic [31:0] id_rs_data, id_rt_data;
   logic [15:0] id_imm;
   logic        stall, flush;
   logic        mem_reg_write;
   logic [4:0]  mem_rd;
   logic [31:0] mem_result;
   logic        wb_reg_write;
   logic [4:0]  wb_rd;
   logic [31:0] wb_result;
   logic        ex_valid;
   logic [31:0] ex_reg1, ex_reg2, ex_store_data;
   logic [2:0]  ex_alu_op;
   logic [4:0]  ex_dest;
   logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_illegal;

   int checks   = 0;
   int failures = 0;

   id_ex_stage dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
      .id_funct(id_funct), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
      .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
      .stall(stall), .flush(flush), .mem_reg_write(mem_reg_write),
      .mem_rd(mem_rd), .mem_result(mem_result), .wb_reg_write(wb_reg_write),
      .wb_rd(wb_rd), .wb_result(wb_result), .ex_valid(ex_valid),
      .ex_reg1(ex_reg1), .ex_reg2(ex_reg2), .ex_alu_op(ex_alu_op),
      .ex_dest(ex_dest), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
      .ex_mem_write(ex_mem_write), .ex_branch(ex_branch),
      .ex_store_data(ex_store_data), .ex_illegal(ex_illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end else begin
         $display("ok   %s = %h", tag, got);
      end
   endtask

   task automatic set_instr(input logic [5:0] op, input logic [5:0] fn,
                            input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                            input logic [31:0] rsd, input logic [31:0] rtd,
                            input logic [15:0] imm);
      id_valid   = 1'b1;
      id_opcode  = op;
      id_funct   = fn;
      id_rs      = rs;
      id_rt      = rt;
      id_rd      = rd;
      id_rs_data = rsd;
      id_rt_data = rtd;
      id_imm     = imm;
   endtask

   // Advance one clock and sample 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Expected forwarded values depend on whether bypassing is built in.
`ifdef ID_EX_FORWARD_EN
   localparam logic [31:0] EXP_MEMWB_RS  = 32'h0000_00AA;
   localparam logic [31:0] EXP_WBONLY_RS = 32'h0000_00BB;
   localparam logic [31:0] EXP_WB_RT     = 32'h0000_00BB;
`else
   localparam logic [31:0] EXP_MEMWB_RS  = 32'h0000_0011;
   localparam logic [31:0] EXP_WBONLY_RS = 32'h0000_0011;
   localparam logic [31:0] EXP_WB_RT     = 32'h0000_0022;
`endif

   initial begin
      rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
      mem_reg_write = 1'b0; mem_rd = '0; mem_result = '0;
      wb_reg_write = 1'b0; wb_rd = '0; wb_result = '0;
      set_instr(OP_RTYPE, FN_ADD, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 16'h0);

      // Held in reset: edges must not load anything.
      step(); step();
      check("rst_valid", {31'b0, ex_valid}, 32'd0);
      check("rst_alu_op", {29'b0, ex_alu_op}, 32'd2);
      check("rst_reg1", ex_reg1, 32'd0);
      check("rst_reg2", ex_reg2, 32'd0);
      check("rst_dest", {27'b0, ex_dest}, 32'd0);
      check("rst_reg_write", {31'b0, ex_reg_write}, 32'd0);
      rst_n = 1'b1;

      // add r3 = r1(5) + r2(7)
      step();
      check("add_op", {29'b0, ex_alu_op}, 32'd2);
      check("add_reg1", ex_reg1, 32'd5);
      check("add_reg2", ex_reg2, 32'd7);
      check("add_dest", {27'b0, ex_dest}, 32'd3);
      check("add_reg_write", {31'b0, ex_reg_write}, 32'd1);
      check("add_valid", {31'b0, ex_valid}, 32'd1);

      set_instr(OP_ADDI, 6'h00, 5'd1, 5'd6, 5'd9, 32'd5, 32'd0, 16'hFFFF);
      step();
      check("addi_reg2", ex_reg2, 32'hFFFF_FFFF);
      check("addi_dest", {27'b0, ex_dest}, 32'd6);
      set_instr(OP_ORI, 6'h00, 5'd1, 5'd6, 5'd9, 32'd5, 32'd0, 16'hFFFF);
      step();
      check("ori_reg2", ex_reg2, 32'h0000_FFFF);
      check("ori_op", {29'b0, ex_alu_op}, 32'd1);
      set_instr(OP_LUI, 6'h00, 5'd0, 5'd7, 5'd0, 32'd0, 32'd0, 16'h1234);
      step();
      check("lui_reg2", ex_reg2, 32'h0000_1234);
      check("lui_op", {29'b0, ex_alu_op}, 32'd3);
      set_instr(OP_SLTI, 6'h00, 5'd1, 5'd8, 5'd0, 32'd5, 32'd0, 16'h8000);
      step();
      check("slti_reg2", ex_reg2, 32'hFFFF_8000);
      check("slti_op", {29'b0, ex_alu_op}, 32'd7);
      set_instr(OP_ANDI, 6'h00, 5'd1, 5'd8, 5'd0, 32'd5, 32'd0, 16'h8000);
      step();
      check("andi_reg2", ex_reg2, 32'h0000_8000);
      check("andi_op", {29'b0, ex_alu_op}, 32'd0);
      set_instr(OP_RTYPE, FN_SUB, 5'd1, 5'd2, 5'd4, 32'd9, 32'd3, 16'h0);
      step();
      check("sub_op", {29'b0, ex_alu_op}, 32'd6);
      check("sub_dest", {27'b0, ex_dest}, 32'd4);
      set_instr(OP_RTYPE, FN_SLT, 5'd1, 5'd2, 5'd4, 32'd9, 32'd3, 16'h0);
      step();
      check("slt_op", {29'b0, ex_alu_op}, 32'd7);
      set_instr(OP_RTYPE, FN_AND, 5'd1, 5'd2, 5'd4, 32'd9, 32'd3, 16'h0);
      step();
      check("and_op", {29'b0, ex_alu_op}, 32'd0);
      set_instr(OP_LW, 6'h00, 5'd1, 5'd5, 5'd0, 32'h100, 32'd0, 16'hFFFC);
      step();
      check("lw_mem_read", {31'b0, ex_mem_read}, 32'd1);
      check("lw_reg2", ex_reg2, 32'hFFFF_FFFC);
      check("lw_reg_write", {31'b0, ex_reg_write}, 32'd1);
      set_instr(OP_SW, 6'h00, 5'd1, 5'd5, 5'd0, 32'h100, 32'hCAFE, 16'h0008);
      step();
      check("sw_mem_write", {31'b0, ex_mem_write}, 32'd1);
      check("sw_reg_write", {31'b0, ex_reg_write}, 32'd0);
      check("sw_store_data", ex_store_data, 32'h0000_CAFE);
      check("sw_reg2", ex_reg2, 32'h0000_0008);
      set_instr(OP_BEQ, 6'h00, 5'd1, 5'd2, 5'd0, 32'd4, 32'd6, 16'h0010);
      step();
      check("beq_branch", {31'b0, ex_branch}, 32'd1);
      check("beq_op", {29'b0, ex_alu_op}, 32'd6);
      check("beq_reg2", ex_reg2, 32'd6);
      check("beq_reg_write", {31'b0, ex_reg_write}, 32'd0);

      // Forwarding: MEM and WB both target r4; MEM must win.
      set_instr(OP_RTYPE, FN_ADD, 5'd4, 5'd5, 5'd6, 32'h11, 32'h22, 16'h0);
      mem_reg_write = 1'b1; mem_rd = 5'd4; mem_result = 32'hAA;
      wb_reg_write  = 1'b1; wb_rd  = 5'd4; wb_result  = 32'hBB;
      step();
      check("fwd_mem_over_wb", ex_reg1, EXP_MEMWB_RS);
      // Combinational re-evaluation without a clock edge.
      mem_reg_write = 1'b0;
      #1;
      check("fwd_wb_only", ex_reg1, EXP_WBONLY_RS);
      wb_rd = 5'd5;
      #1;
      check("fwd_wb_rt", ex_reg2, EXP_WB_RT);
      check("fwd_rs_raw", ex_reg1, 32'h11);
      // r0 is never forwarded.
      set_instr(OP_RTYPE, FN_ADD, 5'd0, 5'd5, 5'd6, 32'h33, 32'h22, 16'h0);
      mem_reg_write = 1'b1; mem_rd = 5'd0; wb_rd = 5'd0;
      step();
      check("fwd_r0_raw", ex_reg1, 32'h33);
      mem_reg_write = 1'b0; wb_reg_write = 1'b0;

      // Stall: load an add, then hold 3 cycles while ID changes.
      set_instr(OP_RTYPE, FN_ADD, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 16'h0);
      step();
      stall = 1'b1;
      set_instr(OP_RTYPE, FN_SUB, 5'd9, 5'd10, 5'd11, 32'd99, 32'd98, 16'h0);
      for (int i = 0; i < 3; i++) begin
         step();
         check($sformatf("stall%0d_reg1", i), ex_reg1, 32'd5);
         check($sformatf("stall%0d_op", i), {29'b0, ex_alu_op}, 32'd2);
         check($sformatf("stall%0d_dest", i), {27'b0, ex_dest}, 32'd3);
      end
      flush = 1'b1;
      step();
      check("flush_valid", {31'b0, ex_valid}, 32'd0);
      check("flush_reg_write", {31'b0, ex_reg_write}, 32'd0);
      check("flush_op", {29'b0, ex_alu_op}, 32'd2);
      check("flush_reg1", ex_reg1, 32'd0);
      stall = 1'b0; flush = 1'b0;

      // id_valid = 0 loads a bubble.
      set_instr(OP_RTYPE, FN_OR, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 16'h0);
      step();
      check("or_op", {29'b0, ex_alu_op}, 32'd1);
      id_valid = 1'b0;
      step();
      check("bubble_valid", {31'b0, ex_valid}, 32'd0);
      check("bubble_op", {29'b0, ex_alu_op}, 32'd2);
      check("bubble_reg_write", {31'b0, ex_reg_write}, 32'd0);

      // Illegal opcode and illegal funct.
      set_instr(6'b111111, 6'h00, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 16'h0);
      step();
      check("ill_op_illegal", {31'b0, ex_illegal}, 32'd1);
      check("ill_op_valid", {31'b0, ex_valid}, 32'd1);
      check("ill_op_reg_write", {31'b0, ex_reg_write}, 32'd0);
      check("ill_op_mem_write", {31'b0, ex_mem_write}, 32'd0);
      check("ill_op_alu_op", {29'b0, ex_alu_op}, 32'd2);
      set_instr(OP_RTYPE, 6'b000111, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 16'h0);
      step();
      check("ill_fn_illegal", {31'b0, ex_illegal}, 32'd1);
      check("ill_fn_reg_write", {31'b0, ex_reg_write}, 32'd0);

      // Asynchronous reset mid-instruction.
      set_instr(OP_ADDI, 6'h00, 5'd1, 5'd3, 5'd0, 32'd5, 32'd0, 16'h0042);
      step();
      check("pre_rst_valid", {31'b0, ex_valid}, 32'd1);
      check("pre_rst_op", {29'b0, ex_alu_op}, 32'd2);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_valid", {31'b0, ex_valid}, 32'd0);
      check("arst_op", {29'b0, ex_alu_op}, 32'd2);
      check("arst_reg1", ex_reg1, 32'd0);
      check("arst_reg2", ex_reg2, 32'd0);
      check("arst_reg_write", {31'b0, ex_reg_write}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register and operand-select stage.
- Sits directly upstream of the 32-bit ALU and drives its reg1, reg2 and 3-bit ALUop inputs.
- Registers decoded-instruction fields, derives the ALU opcode and immediate extension, and resolves RAW hazards by forwarding from the EX/MEM and MEM/WB stages.
- Supports stall (hold) and flush (bubble insertion).

Parameters:
- DATA_W, 32, datapath width.
- REG_AW, 5, register-address width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_opcode  in  6  instruction[31:26]
- id_funct  in  6  instruction[5:0]
- id_rs  in  REG_AW  source register 1 address
- id_rt  in  REG_AW  source register 2 address
- id_rd  in  REG_AW  R-type destination
- id_rs_data  in  DATA_W  register-file read 1
- id_rt_data  in  DATA_W  register-file read 2
- id_imm  in  16  instruction[15:0]
- stall  in  1  hold stage contents
- flush  in  1  replace stage contents with bubble
- mem_reg_write  in  1  EX/MEM writes a register
- mem_rd  in  REG_AW  EX/MEM destination
- mem_result  in  DATA_W  EX/MEM ALU result
- wb_reg_write  in  1  MEM/WB writes a register
- wb_rd  in  REG_AW  MEM/WB destination
- wb_result  in  DATA_W  MEM/WB write-back value
- ex_valid  out  1  stage holds a real instruction
- ex_reg1  out  DATA_W  ALU operand 1
- ex_reg2  out  DATA_W  ALU operand 2
- ex_alu_op  out  3  ALU opcode
- ex_dest  out  REG_AW  write-back destination
- ex_reg_write  out  1  instruction writes a register
- ex_mem_read  out  1  load
- ex_mem_write  out  1  store
- ex_branch  out  1  beq
- ex_store_data  out  DATA_W  forwarded rt value for stores
- ex_illegal  out  1  unrecognised opcode/funct

Behaviour:
- **Reset:** rst_n low asynchronously clears all stage registers. Outputs then read 0, except ex_alu_op = 3'b010 (the bubble encoding). Register 0 is never forwarded, so ex_reg1/ex_reg2 are 0 while held in reset.
- **Capture:** on a clock edge with no stall and no flush, all id_* fields and the decoded controls load.
- **Stall:** contents are held; forwarding outputs still re-evaluate from the current mem/wb inputs.
- **Flush:** loads a bubble: valid = 0, all controls 0, ex_alu_op = 010, rs = rt = 0. Flush has priority over stall.
- **Bubble rule:** id_valid = 0 loads the same bubble as flush.
- **R-type decode (opcode 000000):**
  - funct 100000 ADD -> 010
  - funct 100010 SUB -> 110
  - funct 100100 AND -> 000
  - funct 100101 OR -> 001
  - funct 101010 SLT -> 111
  - dest = rd, reg_write = 1
- **I-type decode (dest = rt, reg_write = 1 unless noted):**
  - addi 001000 -> 010, sign-extended immediate
  - slti 001010 -> 111, sign-extended immediate
  - andi 001100 -> 000, zero-extended immediate
  - ori 001101 -> 001, zero-extended immediate
  - lui 001111 -> 011, zero-extended imm16 presented on reg2; the ALU performs the shift
  - lw 100011 -> 010, sign-extended immediate, mem_read
  - sw 101011 -> 010, sign-extended immediate, mem_write, reg_write = 0
  - beq 000100 -> 110, reg2 = rt operand, branch, reg_write = 0
- **Illegal instruction:** any other opcode/funct with id_valid = 1 gives ex_illegal = 1 and loads bubble-equivalent controls, but ex_valid = 1.
- **Operand select (combinational from registered state):**
  - ex_reg1 = fwd(rs).
  - ex_reg2 = registered extended immediate when alu_src = 1, else fwd(rt).
  - ex_store_data = fwd(rt) always.
- **fwd(r):**
  - mem_result if mem_reg_write && mem_rd == r && r != 0;
  - else wb_result if wb_reg_write && wb_rd == r && r != 0;
  - else the registered register-file data.
  - MEM beats WB when both match.
- **Latency:** one cycle from ID capture to ex_* valid.

Optional Feature:
- Macro: ID_EX_FORWARD_EN.
- Defined: forwarding as specified above.
- Undefined: fwd(r) returns the registered register-file data. The mem_*/wb_* ports remain but are ignored. Software or interlock must schedule around hazards.

Decomposition:
- Shared package (pipe_pkg):
  - ALU opcode constants: AND, OR, ADD, SUB, LUI, SLT.
  - Opcode and funct constants.
  - Bubble control-word constant.
  - DATA_W/REG_AW defaults.
- One sub-module: id_ex_fwd_mux, instantiated twice (rs, rt). It holds the priority compare and r0 exclusion.

Test Plan:
- rst_n low mid-instruction -> all outputs 0 and ex_alu_op = 010 immediately, without waiting for a clock edge.
- add rs=1 (5), rt=2 (7), rd=3, no hazards -> next cycle ex_alu_op = 010, ex_reg1 = 5, ex_reg2 = 7, ex_dest = 3, ex_reg_write = 1.
- addi imm=16'hFFFF, then ori imm=16'hFFFF -> ex_reg2 = 32'hFFFFFFFF, then 32'h0000FFFF; lui imm=16'h1234 -> ex_reg2 = 32'h00001234, op 011.
- Forwarding (ID_EX_FORWARD_EN defined):
  - rs=4 with mem_rd=4 (result 32'hAA) and wb_rd=4 (result 32'hBB) -> ex_reg1 = 32'hAA.
  - rs=0 with mem_rd=0 -> ex_reg1 = raw data.
- stall held 3 cycles while id_* change -> ex_* unchanged; stall and flush asserted together -> ex_valid = 0, ex_reg_write = 0.
- opcode 111111 with id_valid = 1 -> ex_illegal = 1, ex_valid = 1, ex_reg_write = 0, ex_mem_write = 0.
